// File: rtl/serial_link_chan_sched.sv
// -----------------------------------------------------------------------------
// serial_link_chan_sched
//
// Credit-based round-robin scheduler that packs several AXI channels
// (AW, W, B, AR, R) onto one serial link. Each cycle, one eligible channel is
// granted. A channel is eligible when it is valid and has remote credit. The
// granted payload is registered as {tag, payload}, where the tag is the
// channel index.
//
// Ports
//   clk_i         clock; all state updates on its rising edge
//   rst_ni        synchronous active-low reset
//   chan_valid_i  per-channel payload valid
//   chan_data_i   per-channel payload, slot i at [i*MaxChWidth +: MaxChWidth]
//   chan_ready_o  per-channel grant (one-hot or zero)
//   pkt_valid_o   outgoing packet valid
//   pkt_data_o    outgoing packet {tag, payload}
//   pkt_ready_i   downstream accepts the packet
//   credit_ret_i  per-channel pulse; one remote buffer slot has been freed
//   credits_o     flattened per-channel credit counts, CntW bits each
//   credit_err_o  sticky flag; a credit was returned to a full counter
// -----------------------------------------------------------------------------
module serial_link_chan_sched #(
  parameter int NumChan    = 5,
  parameter int MaxChWidth = 38,
  parameter int NumCredits = 8,
  localparam int CntW      = $clog2(NumCredits + 1),
  localparam int TagW      = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumChan-1:0]            chan_valid_i,
  input  logic [NumChan*MaxChWidth-1:0] chan_data_i,
  output logic [NumChan-1:0]            chan_ready_o,
  output logic                          pkt_valid_o,
  output logic [TagW+MaxChWidth-1:0]    pkt_data_o,
  input  logic                          pkt_ready_i,
  input  logic [NumChan-1:0]            credit_ret_i,
  output logic [NumChan*CntW-1:0]       credits_o,
  output logic                          credit_err_o
);

  logic [CntW-1:0]       credits_q [NumChan];
  logic [TagW-1:0]       ptr_q;
  logic [NumChan-1:0]    eligible;
  logic                  out_free;
  logic                  found;
  logic                  grant;
  logic [TagW-1:0]       grant_idx;
  logic [MaxChWidth-1:0] grant_payload;

  assign out_free = !pkt_valid_o || pkt_ready_i;
  assign grant    = found && out_free && rst_ni;

  // Round-robin search starting at ptr_q. Position k of the search maps to
  // channel i when ptr_q + k equals i, either directly or after one wrap.
  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a
    // path that skips an assignment would infer a latch.
    eligible      = '0;
    found         = 1'b0;
    grant_idx     = '0;
    grant_payload = '0;
    chan_ready_o  = '0;
    for (int i = 0; i < NumChan; i++) begin
      eligible[i] = chan_valid_i[i] && (credits_q[i] != '0);
    end
    for (int k = 0; k < NumChan; k++) begin
      for (int i = 0; i < NumChan; i++) begin
        if (!found && eligible[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + NumChan))) begin
          found     = 1'b1;
          grant_idx = TagW'(i);
        end
      end
    end
    for (int i = 0; i < NumChan; i++) begin
      if (grant_idx == TagW'(i)) begin
        grant_payload = chan_data_i[i*MaxChWidth +: MaxChWidth];
        chan_ready_o[i] = grant;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!rst_ni) begin
      pkt_valid_o <= 1'b0;
      pkt_data_o  <= '0;
      ptr_q       <= '0;
    end else if (grant) begin
      pkt_valid_o <= 1'b1;
      pkt_data_o  <= {grant_idx, grant_payload};
      ptr_q       <= (grant_idx == TagW'(NumChan - 1)) ? '0 : grant_idx + 1'b1;
    end else if (pkt_ready_i) begin
      // Drained with no replacement; the data is left as is because it is
      // qualified by pkt_valid_o.
      pkt_valid_o <= 1'b0;
    end
  end

  // Credit counters: credits + return - grant. A grant needs a non-zero count,
  // so only the return path can overflow, and the count saturates there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the credit array is a handful of flops, not a RAM, so each
      // entry is reset explicitly to the full remote buffer depth.
      for (int i = 0; i < NumChan; i++) begin
        credits_q[i] <= CntW'(NumCredits);
      end
      credit_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < NumChan; i++) begin
        if (credit_ret_i[i] && !chan_ready_o[i]) begin
          if (credits_q[i] == CntW'(NumCredits)) begin
            credit_err_o <= 1'b1;
          end else begin
            credits_q[i] <= credits_q[i] + 1'b1;
          end
        end else if (!credit_ret_i[i] && chan_ready_o[i]) begin
          credits_q[i] <= credits_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    credits_o = '0;
    for (int i = 0; i < NumChan; i++) begin
      credits_o[i*CntW +: CntW] = credits_q[i];
    end
  end

endmodule

// File: tb/tb_serial_link_chan_sched.sv
// -----------------------------------------------------------------------------
// tb_serial_link_chan_sched
//
// Directed bench for serial_link_chan_sched with default parameters
// (5 channels, 38-bit payload, 8 credits). Inputs change 1 ns after each
// rising edge. The combinational grant is sampled 1 ns after that. Registered
// outputs are sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_serial_link_chan_sched;

  localparam int NumChan    = 5;
  localparam int MaxChWidth = 38;
  localparam int NumCredits = 8;
  localparam int CntW       = 4;
  localparam int TagW       = 3;

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic [NumChan-1:0]            chan_valid_i;
  logic [NumChan*MaxChWidth-1:0] chan_data_i;
  logic [NumChan-1:0]            chan_ready_o;
  logic                          pkt_valid_o;
  logic [TagW+MaxChWidth-1:0]    pkt_data_o;
  logic                          pkt_ready_i;
  logic [NumChan-1:0]            credit_ret_i;
  logic [NumChan*CntW-1:0]       credits_o;
  logic                          credit_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  serial_link_chan_sched #(
    .NumChan    (NumChan),
    .MaxChWidth (MaxChWidth),
    .NumCredits (NumCredits)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .chan_valid_i (chan_valid_i),
    .chan_data_i  (chan_data_i),
    .chan_ready_o (chan_ready_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_data_o   (pkt_data_o),
    .pkt_ready_i  (pkt_ready_i),
    .credit_ret_i (credit_ret_i),
    .credits_o    (credits_o),
    .credit_err_o (credit_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Upper payload bits are set to show that the payload passes through unchanged.
  function automatic logic [MaxChWidth-1:0] slot_val(int i);
    return 38'h25_C3A5_0F00 | MaxChWidth'(i);
  endfunction

  function automatic logic [TagW+MaxChWidth-1:0] exp_pkt(int i);
    return {TagW'(i), slot_val(i)};
  endfunction

  function automatic logic [CntW-1:0] cred(int i);
    return credits_o[i*CntW +: CntW];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni       = 1'b0;
    chan_valid_i = '0;
    credit_ret_i = '0;
    pkt_ready_i  = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni       = 1'b0;
    chan_valid_i = '1;
    credit_ret_i = '1;
    pkt_ready_i  = 1'b1;
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00000", chan_ready_o);
    end
    tick();
    n_checks++;
    if (pkt_valid_o !== 1'b0 || pkt_data_o !== '0) begin
      n_fail++; $display("FAIL reset_pkt: got v=%b d=%h want v=0 d=0", pkt_valid_o, pkt_data_o);
    end
    for (int i = 0; i < NumChan; i++) begin
      n_checks++;
      if (cred(i) !== 4'd8) begin
        n_fail++; $display("FAIL reset_credits ch%0d: got %0d want 8", i, cred(i));
      end
    end
    n_checks++;
    if (credit_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b want 0", credit_err_o);
    end
    rst_ni       = 1'b1;
    chan_valid_i = '0;
    credit_ret_i = '0;
    pkt_ready_i  = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_cred [NumChan];
    int g;
    apply_reset();
    for (int i = 0; i < NumChan; i++) exp_cred[i] = NumCredits;
    chan_valid_i = 5'b11111;
    pkt_ready_i  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = k % NumChan;
      #1;
      n_checks++;
      if (chan_ready_o !== 5'(1 << g)) begin
        n_fail++; $display("FAIL rr_grant step%0d: got %b want %b", k, chan_ready_o, 5'(1 << g));
      end
      tick();
      exp_cred[g]--;
      n_checks++;
      if (pkt_valid_o !== 1'b1 || pkt_data_o !== exp_pkt(g)) begin
        n_fail++; $display("FAIL rr_pkt step%0d: got v=%b d=%h want v=1 d=%h", k, pkt_valid_o, pkt_data_o, exp_pkt(g));
      end
      n_checks++;
      if (cred(g) !== 4'(exp_cred[g])) begin
        n_fail++; $display("FAIL rr_credit step%0d ch%0d: got %0d want %0d", k, g, cred(g), exp_cred[g]);
      end
    end
    chan_valid_i = '0;
    tick();
    n_checks++;
    if (pkt_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_drain: got v=%b want 0", pkt_valid_o);
    end
  endtask

  task automatic test_credit_exhaust();
    apply_reset();
    chan_valid_i = 5'b00010;
    pkt_ready_i  = 1'b1;
    for (int n = 0; n < NumCredits; n++) begin
      #1;
      n_checks++;
      if (chan_ready_o !== 5'b00010) begin
        n_fail++; $display("FAIL exh_grant n=%0d: got %b want 00010", n, chan_ready_o);
      end
      tick();
      n_checks++;
      if (pkt_data_o !== exp_pkt(1) || cred(1) !== 4'(7 - n)) begin
        n_fail++; $display("FAIL exh_pkt n=%0d: got d=%h c=%0d want d=%h c=%0d", n, pkt_data_o, cred(1), exp_pkt(1), 7 - n);
      end
    end
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00000 || cred(1) !== 4'd0) begin
      n_fail++; $display("FAIL exh_empty: got r=%b c=%0d want r=00000 c=0", chan_ready_o, cred(1));
    end
    tick();
    n_checks++;
    if (pkt_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL exh_drain: got v=%b want 0", pkt_valid_o);
    end
    // A return at zero credit does not allow a grant in the same cycle.
    credit_ret_i = 5'b00010;
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00000) begin
      n_fail++; $display("FAIL exh_ret_same_cycle: got %b want 00000", chan_ready_o);
    end
    tick();
    credit_ret_i = '0;
    n_checks++;
    if (cred(1) !== 4'd1) begin
      n_fail++; $display("FAIL exh_ret_credit: got %0d want 1", cred(1));
    end
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00010) begin
      n_fail++; $display("FAIL exh_regrant: got %b want 00010", chan_ready_o);
    end
    tick();
    n_checks++;
    if (pkt_valid_o !== 1'b1 || pkt_data_o !== exp_pkt(1) || cred(1) !== 4'd0) begin
      n_fail++; $display("FAIL exh_last_pkt: got v=%b d=%h c=%0d want v=1 d=%h c=0", pkt_valid_o, pkt_data_o, cred(1), exp_pkt(1));
    end
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00000) begin
      n_fail++; $display("FAIL exh_only_one: got %b want 00000", chan_ready_o);
    end
    chan_valid_i = '0;
  endtask

  task automatic test_backpressure();
    logic [TagW+MaxChWidth-1:0] held;
    apply_reset();
    chan_valid_i = 5'b00101;
    pkt_ready_i  = 1'b0;
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00001) begin
      n_fail++; $display("FAIL bp_first_grant: got %b want 00001", chan_ready_o);
    end
    tick();
    held = exp_pkt(0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (chan_ready_o !== 5'b00000) begin
        n_fail++; $display("FAIL bp_ready_stall c=%0d: got %b want 00000", c, chan_ready_o);
      end
      tick();
      n_checks++;
      if (pkt_valid_o !== 1'b1 || pkt_data_o !== held) begin
        n_fail++; $display("FAIL bp_hold c=%0d: got v=%b d=%h want v=1 d=%h", c, pkt_valid_o, pkt_data_o, held);
      end
    end
    pkt_ready_i = 1'b1;
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00100) begin
      n_fail++; $display("FAIL bp_release_grant: got %b want 00100", chan_ready_o);
    end
    tick();
    n_checks++;
    if (pkt_data_o !== exp_pkt(2) || cred(0) !== 4'd7 || cred(2) !== 4'd7) begin
      n_fail++; $display("FAIL bp_next_pkt: got d=%h c0=%0d c2=%0d want d=%h c0=7 c2=7", pkt_data_o, cred(0), cred(2), exp_pkt(2));
    end
    chan_valid_i = '0;
  endtask

  task automatic test_grant_and_return();
    apply_reset();
    chan_valid_i = 5'b00100;
    pkt_ready_i  = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (cred(2) !== 4'd5) begin
      n_fail++; $display("FAIL gr_setup: got %0d want 5", cred(2));
    end
    credit_ret_i = 5'b00100;
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00100) begin
      n_fail++; $display("FAIL gr_grant: got %b want 00100", chan_ready_o);
    end
    tick();
    credit_ret_i = '0;
    chan_valid_i = '0;
    n_checks++;
    if (cred(2) !== 4'd5 || credit_err_o !== 1'b0) begin
      n_fail++; $display("FAIL gr_credit: got c=%0d e=%b want c=5 e=0", cred(2), credit_err_o);
    end
  endtask

  task automatic test_credit_overflow();
    apply_reset();
    credit_ret_i = 5'b00001;
    tick();
    credit_ret_i = '0;
    n_checks++;
    if (cred(0) !== 4'd8 || credit_err_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got c=%0d e=%b want c=8 e=1", cred(0), credit_err_o);
    end
    tick();
    tick();
    n_checks++;
    if (credit_err_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b want 1", credit_err_o);
    end
    apply_reset();
    n_checks++;
    if (credit_err_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", credit_err_o);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    chan_valid_i = 5'b10000;
    pkt_ready_i  = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    chan_valid_i = 5'b00010;
    pkt_ready_i  = 1'b1;
    tick();
    pkt_ready_i = 1'b0;
    n_checks++;
    if (pkt_valid_o !== 1'b1 || pkt_data_o !== exp_pkt(1) || cred(4) !== 4'd3) begin
      n_fail++; $display("FAIL mr_setup: got v=%b d=%h c4=%0d want v=1 d=%h c4=3", pkt_valid_o, pkt_data_o, cred(4), exp_pkt(1));
    end
    rst_ni       = 1'b0;
    chan_valid_i = 5'b11111;
    credit_ret_i = 5'b11111;
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00000) begin
      n_fail++; $display("FAIL mr_ready_in_reset: got %b want 00000", chan_ready_o);
    end
    tick();
    rst_ni       = 1'b1;
    credit_ret_i = '0;
    n_checks++;
    if (pkt_valid_o !== 1'b0 || pkt_data_o !== '0 || cred(4) !== 4'd8 || cred(1) !== 4'd8) begin
      n_fail++; $display("FAIL mr_state: got v=%b d=%h c4=%0d c1=%0d want v=0 d=0 c4=8 c1=8", pkt_valid_o, pkt_data_o, cred(4), cred(1));
    end
    pkt_ready_i = 1'b1;
    #1;
    n_checks++;
    if (chan_ready_o !== 5'b00001) begin
      n_fail++; $display("FAIL mr_ptr: got %b want 00001", chan_ready_o);
    end
    chan_valid_i = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NumChan; i++) begin
      chan_data_i[i*MaxChWidth +: MaxChWidth] = slot_val(i);
    end
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_backpressure();
    test_grant_and_return();
    test_credit_overflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
